// File: rtl/skip_unit.sv
// PDP-8 skip-condition evaluator: OPR group-2 skips, ISZ increment/skip and IOT
// device-flag skips. The decision is registered and held until the PC logic takes it.
module skip_unit #(
   parameter int WIDTH = 12,
   parameter int NDEV  = 8,
   parameter int DSW   = (NDEV > 2) ? $clog2(NDEV) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             EVAL,
   input  logic [1:0]       MODE,
   input  logic [WIDTH-1:0] AC,
   input  logic             LINK,
   input  logic             SZASNA,
   input  logic             SMASPA,
   input  logic             SNLSZL,
   input  logic             TSTINV,
   input  logic [WIDTH-1:0] MEM,
   input  logic [DSW-1:0]   DEVSEL,
   input  logic [NDEV-1:0]  DEVFLAG,
   input  logic             TAKE,
   output logic             BUSY,
   output logic             DONE,
   output logic             SKIP,
   output logic [WIDTH-1:0] ISZ_RESULT,
   output logic             ISZ_WE,
   output logic             OVERRUN
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_HOLD} state_t;

   localparam logic [1:0] M_OPR = 2'b00;
   localparam logic [1:0] M_ISZ = 2'b01;
   localparam logic [1:0] M_IOT = 2'b10;

   state_t           r_state;
   logic [1:0]       r_mode;
   logic [WIDTH-1:0] r_ac, r_mem, r_isz_res;
   logic             r_link, r_sza, r_sma, r_snl, r_inv, r_flag;
   logic             r_busy, r_done, r_skip, r_isz_we, r_overrun;

   logic             w_dev_flag, w_opr_c, w_skip, w_accept;
   logic [WIDTH-1:0] w_inc;

   // Out-of-range device selects read as a cleared flag.
   always_comb begin
      w_dev_flag = 1'b0;
      for (int i = 0; i < NDEV; i++)
         if (32'(DEVSEL) == i) w_dev_flag = DEVFLAG[i];
   end

   assign w_inc   = r_mem + 1'b1;
   assign w_opr_c = (r_sza & ~|r_ac) | (r_sma & r_ac[WIDTH-1]) | (r_snl & r_link);

   always_comb begin
      w_skip = 1'b0;
      case (r_mode)
         M_OPR:   w_skip = w_opr_c ^ r_inv;
         M_ISZ:   w_skip = ~|w_inc;
         M_IOT:   w_skip = r_flag;
         default: w_skip = 1'b0;
      endcase
   end

   assign w_accept = EVAL & ((r_state == S_IDLE) | ((r_state == S_HOLD) & TAKE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_mode    <= '0;
         r_ac      <= '0;
         r_mem     <= '0;
         r_isz_res <= '0;
         r_link    <= 1'b0;
         r_sza     <= 1'b0;
         r_sma     <= 1'b0;
         r_snl     <= 1'b0;
         r_inv     <= 1'b0;
         r_flag    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_skip    <= 1'b0;
         r_isz_we  <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done   <= 1'b0;
         r_isz_we <= 1'b0;
         if (w_accept) begin
            r_mode <= MODE;
            r_ac   <= AC;
            r_link <= LINK;
            r_sza  <= SZASNA;
            r_sma  <= SMASPA;
            r_snl  <= SNLSZL;
            r_inv  <= TSTINV;
            r_mem  <= MEM;
            r_flag <= w_dev_flag;
         end
         case (r_state)
            S_IDLE: begin
               if (EVAL) begin
                  r_state <= S_CALC;
                  r_busy  <= 1'b1;
               end
            end
            S_CALC: begin
               r_state <= S_HOLD;
               r_skip  <= w_skip;
               r_done  <= 1'b1;
               if (r_mode == M_ISZ) begin
                  r_isz_we  <= 1'b1;
                  r_isz_res <= w_inc;
               end
               if (EVAL) r_overrun <= 1'b1;
            end
            S_HOLD: begin
               if (TAKE) begin
                  r_skip <= 1'b0;
                  if (EVAL) r_state <= S_CALC;
                  else begin
                     r_state <= S_IDLE;
                     r_busy  <= 1'b0;
                  end
               end else if (EVAL) begin
                  r_overrun <= 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY       = r_busy;
   assign DONE       = r_done;
   assign SKIP       = r_skip;
   assign ISZ_RESULT = r_isz_res;
   assign ISZ_WE     = r_isz_we;
   assign OVERRUN    = r_overrun;

endmodule

// File: tb/tb_skip_unit.sv
// Scoreboard bench for skip_unit: a 12-bit/8-device instance and an 8-bit/2-device
// instance; stimulus pushes expectations, one negedge monitor does all comparisons.
module tb_skip_unit;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // instance A: WIDTH=12, NDEV=8
   logic        a_eval = 0, a_link = 0, a_sza = 0, a_sma = 0, a_snl = 0, a_inv = 0, a_take = 0;
   logic [1:0]  a_mode = 0;
   logic [11:0] a_ac = 0, a_mem = 0;
   logic [2:0]  a_ds = 0;
   logic [7:0]  a_df = 0;
   logic        A_BUSY, A_DONE, A_SKIP, A_WE, A_OVR;
   logic [11:0] A_RES;

   skip_unit #(.WIDTH(12), .NDEV(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .EVAL(a_eval), .MODE(a_mode), .AC(a_ac), .LINK(a_link),
      .SZASNA(a_sza), .SMASPA(a_sma), .SNLSZL(a_snl), .TSTINV(a_inv), .MEM(a_mem),
      .DEVSEL(a_ds), .DEVFLAG(a_df), .TAKE(a_take), .BUSY(A_BUSY), .DONE(A_DONE),
      .SKIP(A_SKIP), .ISZ_RESULT(A_RES), .ISZ_WE(A_WE), .OVERRUN(A_OVR));

   // instance B: WIDTH=8, NDEV=2, DEVSEL widened so out-of-range selects are reachable
   logic        b_eval = 0, b_take = 0;
   logic [1:0]  b_mode = 0;
   logic [7:0]  b_ac = 0, b_mem = 0;
   logic [2:0]  b_ds = 0;
   logic [1:0]  b_df = 0;
   logic        b_zero = 0;
   logic        B_BUSY, B_DONE, B_SKIP, B_WE, B_OVR;
   logic [7:0]  B_RES;

   skip_unit #(.WIDTH(8), .NDEV(2), .DSW(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .EVAL(b_eval), .MODE(b_mode), .AC(b_ac), .LINK(b_zero),
      .SZASNA(b_zero), .SMASPA(b_zero), .SNLSZL(b_zero), .TSTINV(b_zero), .MEM(b_mem),
      .DEVSEL(b_ds), .DEVFLAG(b_df), .TAKE(b_take), .BUSY(B_BUSY), .DONE(B_DONE),
      .SKIP(B_SKIP), .ISZ_RESULT(B_RES), .ISZ_WE(B_WE), .OVERRUN(B_OVR));

   typedef struct { logic skip; logic we; logic [11:0] res; int cyc; } sc_t;
   typedef struct { int kind; logic [31:0] exp; } chk_t;

   localparam int KA_BUSY = 0, KA_DONE = 1, KA_SKIP = 2, KA_RES = 3, KA_WE = 4,
                  KA_OVR = 5, KA_QEMPTY = 6, KB_BUSY = 7, KB_SKIP = 8, KB_QEMPTY = 9;

   sc_t  qa[$], qb[$];
   chk_t sq[$];
   int   pass = 0, total = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   sc_t  me;
   chk_t mc;
   always @(negedge clk) begin
      while (sq.size() > 0) begin
         mc = sq.pop_front();
         case (mc.kind)
            KA_BUSY:   chk("a_busy", 32'(A_BUSY), mc.exp);
            KA_DONE:   chk("a_done", 32'(A_DONE), mc.exp);
            KA_SKIP:   chk("a_skip", 32'(A_SKIP), mc.exp);
            KA_RES:    chk("a_isz_result", 32'(A_RES), mc.exp);
            KA_WE:     chk("a_isz_we", 32'(A_WE), mc.exp);
            KA_OVR:    chk("a_overrun", 32'(A_OVR), mc.exp);
            KA_QEMPTY: chk("a_pending", 32'(qa.size()), mc.exp);
            KB_BUSY:   chk("b_busy", 32'(B_BUSY), mc.exp);
            KB_SKIP:   chk("b_skip", 32'(B_SKIP), mc.exp);
            KB_QEMPTY: chk("b_pending", 32'(qb.size()), mc.exp);
            default:   chk("bad_kind", 32'(mc.kind), 32'(KA_BUSY));
         endcase
      end
      if (A_DONE) begin
         if (qa.size() == 0) chk("a_done_unexpected", 32'(A_DONE), 0);
         else begin
            me = qa.pop_front();
            chk("a_skip@done", 32'(A_SKIP), 32'(me.skip));
            chk("a_latency", cyc, me.cyc);
            chk("a_we@done", 32'(A_WE), 32'(me.we));
            if (me.we) chk("a_isz_result@done", 32'(A_RES), 32'(me.res));
         end
      end else if (A_WE) chk("a_we_without_done", 32'(A_WE), 0);
      if (B_DONE) begin
         if (qb.size() == 0) chk("b_done_unexpected", 32'(B_DONE), 0);
         else begin
            me = qb.pop_front();
            chk("b_skip@done", 32'(B_SKIP), 32'(me.skip));
            chk("b_latency", cyc, me.cyc);
            chk("b_we@done", 32'(B_WE), 32'(me.we));
            if (me.we) chk("b_isz_result@done", 32'(B_RES), 32'({4'b0, me.res[7:0]}));
         end
      end else if (B_WE) chk("b_we_without_done", 32'(B_WE), 0);
   end

   task automatic push(input int k, input logic [31:0] v);
      sq.push_back('{kind: k, exp: v});
   endtask

   task automatic set_a(input logic [1:0] m, input logic [11:0] ac, input logic l, sza, sma, snl,
                        inv, input logic [11:0] mem, input logic [2:0] ds, input logic [7:0] df);
      a_mode = m; a_ac = ac; a_link = l; a_sza = sza; a_sma = sma; a_snl = snl;
      a_inv = inv; a_mem = mem; a_ds = ds; a_df = df;
   endtask

   // Changes every captured input so a result that leaks live inputs shows up.
   task automatic scramble_a();
      a_mode = ~a_mode; a_ac = ~a_ac; a_link = ~a_link; a_sza = ~a_sza; a_sma = ~a_sma;
      a_snl = ~a_snl; a_inv = ~a_inv; a_mem = ~a_mem; a_df = 8'h00;
   endtask

   task automatic exp_a(input logic sk, input logic we, input logic [11:0] res);
      qa.push_back('{skip: sk, we: we, res: res, cyc: cyc + 2});
   endtask

   task automatic wait_done_a();
      for (int k = 0; k < 6 && !A_DONE; k++) begin @(posedge clk); #1; end
      if (!A_DONE) push(KA_DONE, 1);
   endtask

   task automatic take_a();
      a_take = 1; @(posedge clk); #1; a_take = 0;
      push(KA_BUSY, 0); push(KA_SKIP, 0);
   endtask

   task automatic run_a(input logic [1:0] m, input logic [11:0] ac, input logic l, sza, sma, snl,
                        inv, input logic [11:0] mem, input logic [2:0] ds, input logic [7:0] df,
                        input logic sk, input logic we, input logic [11:0] res, input int hold);
      set_a(m, ac, l, sza, sma, snl, inv, mem, ds, df);
      a_eval = 1; exp_a(sk, we, res);
      @(posedge clk); #1; a_eval = 0; scramble_a();
      wait_done_a();
      repeat (hold) begin @(posedge clk); #1; end
      if (hold > 0) begin push(KA_SKIP, 32'(sk)); push(KA_BUSY, 1); end
      take_a();
   endtask

   task automatic run_b(input logic [1:0] m, input logic [7:0] mem, input logic [2:0] ds,
                        input logic [1:0] df, input logic sk, input logic we, input logic [7:0] res);
      b_mode = m; b_mem = mem; b_ds = ds; b_df = df; b_eval = 1;
      qb.push_back('{skip: sk, we: we, res: {4'b0, res}, cyc: cyc + 2});
      @(posedge clk); #1; b_eval = 0; b_mem = ~b_mem; b_df = ~b_df; b_mode = ~b_mode;
      for (int k = 0; k < 6 && !B_DONE; k++) begin @(posedge clk); #1; end
      b_take = 1; @(posedge clk); #1; b_take = 0;
      push(KB_BUSY, 0); push(KB_SKIP, 0);
   endtask

   initial begin
      // reset state
      #2;
      push(KA_BUSY, 0); push(KA_DONE, 0); push(KA_SKIP, 0);
      push(KA_RES, 0); push(KA_WE, 0); push(KA_OVR, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk); #1;

      // OPR: SZA, SNA, SPA, SMA, SKP (held 3 cycles), SNL
      run_a(2'b00, 12'o0000, 0, 1, 0, 0, 0, 12'o0, 3'd0, 8'h00, 1, 0, 12'o0, 0);
      run_a(2'b00, 12'o0001, 0, 1, 0, 0, 0, 12'o0, 3'd0, 8'h00, 0, 0, 12'o0, 0);
      run_a(2'b00, 12'o0000, 0, 1, 0, 0, 1, 12'o0, 3'd0, 8'h00, 0, 0, 12'o0, 0);
      run_a(2'b00, 12'o4000, 0, 0, 1, 0, 1, 12'o0, 3'd0, 8'h00, 0, 0, 12'o0, 0);
      run_a(2'b00, 12'o4000, 0, 0, 1, 0, 0, 12'o0, 3'd0, 8'h00, 1, 0, 12'o0, 0);
      run_a(2'b00, 12'o1234, 0, 0, 0, 0, 1, 12'o0, 3'd0, 8'h00, 1, 0, 12'o0, 3);
      run_a(2'b00, 12'o7777, 1, 0, 0, 1, 0, 12'o0, 3'd0, 8'h00, 1, 0, 12'o0, 0);
      // ISZ
      run_a(2'b01, 12'o0000, 0, 0, 0, 0, 0, 12'o7777, 3'd0, 8'h00, 1, 1, 12'o0000, 0);
      run_a(2'b01, 12'o0000, 0, 0, 0, 0, 0, 12'o0005, 3'd0, 8'h00, 0, 1, 12'o0006, 0);
      // IOT: flag cleared after capture, then a different device
      run_a(2'b10, 12'o0000, 0, 0, 0, 0, 0, 12'o0, 3'd3, 8'b0000_1000, 1, 0, 12'o0, 0);
      run_a(2'b10, 12'o0000, 0, 0, 0, 0, 0, 12'o0, 3'd2, 8'b0000_1000, 0, 0, 12'o0, 0);
      // reserved mode: no skip, no write-back even with skip-looking operands
      run_a(2'b11, 12'o0000, 1, 1, 1, 1, 1, 12'o7777, 3'd3, 8'hFF, 0, 0, 12'o0, 0);

      // narrow instance
      run_b(2'b01, 8'hFF, 3'd0, 2'b00, 1, 1, 8'h00);
      run_b(2'b01, 8'h7F, 3'd0, 2'b00, 0, 1, 8'h80);
      run_b(2'b10, 8'h00, 3'd3, 2'b11, 0, 0, 8'h00);
      run_b(2'b10, 8'h00, 3'd1, 2'b10, 1, 0, 8'h00);

      // EVAL during CALC is dropped; then TAKE+EVAL in the DONE cycle
      set_a(2'b00, 12'o0000, 0, 1, 0, 0, 0, 12'o0, 3'd0, 8'h00);
      a_eval = 1; exp_a(1, 0, 12'o0);
      @(posedge clk); #1;
      set_a(2'b00, 12'o0001, 0, 1, 0, 0, 0, 12'o0, 3'd0, 8'h00);
      @(posedge clk); #1; a_eval = 0;
      push(KA_OVR, 1); push(KA_DONE, 1);
      set_a(2'b01, 12'o0000, 0, 0, 0, 0, 0, 12'o0005, 3'd0, 8'h00);
      a_take = 1; a_eval = 1; exp_a(0, 1, 12'o0006);
      @(posedge clk); #1; a_take = 0; a_eval = 0; scramble_a();
      push(KA_BUSY, 1);
      wait_done_a();
      take_a();

      // reset during ISZ CALC
      set_a(2'b01, 12'o0000, 0, 0, 0, 0, 0, 12'o7777, 3'd0, 8'h00);
      a_eval = 1;
      @(posedge clk); #1; a_eval = 0;
      #1 rst_n = 0;
      push(KA_BUSY, 0); push(KA_DONE, 0); push(KA_SKIP, 0);
      push(KA_RES, 0); push(KA_WE, 0); push(KA_OVR, 0);
      @(posedge clk); #1 rst_n = 1;
      repeat (5) @(posedge clk);
      #1;
      push(KA_QEMPTY, 0); push(KB_QEMPTY, 0); push(KA_BUSY, 0);
      @(negedge clk); #1;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
